rst_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/rst_sync.sv | 25 ++
 rtl/rst_seq.sv | 176 +++++++++++++++++
 tb/tb_rst_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Purpose : shared state encoding and counter width for the power-up reset sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    PWR   = 3'd1,
    CFG   = 3'd2,
    LINK  = 3'd3,
    RUN   = 3'd4,
    FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/rst_sync.sv
// Purpose : async-assert / sync-deassert reset synchronizer, SYNC_STAGES flops deep.
// Latency : rst_sync_n rises SYNC_STAGES clk edges after rst_n rises; falls immediately with rst_n.
// Backpressure: none.
// Ports   : clk, rst_n (async active-low in), rst_sync_n (synchronized active-low out).
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Purpose : power-up reset sequencer: ADC power -> settle -> ADC reset release/config -> link release -> sys_ready.
// Latency : adc_pwr_en rises SYNC_STAGES+1 edges after rst_n; all outputs registered, one edge per transition.
// Backpressure: none; soft_rst_req restarts from PWR in any state but HOLD, adc_cfg_done is a level handshake.
// Ports   : clk, rst_n, soft_rst_req, adc_cfg_done in; adc_pwr_en, adc_rst_n, adc_cfg_start,
//           link_rst_n, sys_ready, cfg_err, seq_state[2:0] out.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] PWR_WAIT    = 16'd2000,
  parameter logic [CNT_W-1:0] CFG_TIMEOUT = 16'd20000,
  parameter logic [CNT_W-1:0] LINK_WAIT   = 16'd64,
  parameter logic [1:0]       MAX_RETRY   = 2'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       adc_cfg_done,
  output logic       adc_pwr_en,
  output logic       adc_rst_n,
  output logic       adc_cfg_start,
  output logic       link_rst_n,
  output logic       sys_ready,
  output logic       cfg_err,
  output logic [2:0] seq_state
);

  logic rst_sync_n;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             pwr_q, pwr_d;
  logic             arst_q, arst_d;
  logic             start_q, start_d;
  logic             link_q, link_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      pwr_q   <= 1'b0;
      arst_q  <= 1'b0;
      start_q <= 1'b0;
      link_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pwr_q   <= pwr_d;
      arst_q  <= arst_d;
      start_q <= start_d;
      link_q  <= link_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    pwr_d   = pwr_q;
    arst_d  = arst_q;
    start_d = 1'b0;       // config-start is a single-cycle pulse
    link_d  = link_q;
    ready_d = ready_q;
    err_d   = err_q;

    // Soft restart overrides every other transition but is ignored while still in HOLD.
    if (soft_rst_req && (state_q inside {PWR, CFG, LINK, RUN, FAULT})) begin
      state_d = PWR;
      cnt_d   = '0;
      retry_d = '0;
      pwr_d   = 1'b1;
      arst_d  = 1'b0;
      link_d  = 1'b0;
      ready_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = PWR;
          pwr_d   = 1'b1;
          cnt_d   = '0;
        end
        PWR: begin
          if (cnt_q == PWR_WAIT - CNT_W'(1)) begin
            state_d = CFG;
            arst_d  = 1'b1;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CFG: begin
          // done is checked first so it wins a tie with the timeout
          if (adc_cfg_done) begin
            state_d = LINK;
            link_d  = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == CFG_TIMEOUT - CNT_W'(1)) begin
            cnt_d  = '0;
            arst_d = 1'b0;
            if (retry_q < MAX_RETRY) begin
              state_d = PWR;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = FAULT;
              err_d   = 1'b1;
              link_d  = 1'b0;
              ready_d = 1'b0;
              pwr_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LINK: begin
          if (cnt_q == LINK_WAIT - CNT_W'(1)) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        FAULT: begin
          state_d = FAULT;
          err_d   = 1'b1;
          pwr_d   = 1'b1;
          arst_d  = 1'b0;
          link_d  = 1'b0;
          ready_d = 1'b0;
        end
        default: begin
          // unused encodings fall back to HOLD with everything deasserted
          state_d = HOLD;
          cnt_d   = '0;
          retry_d = '0;
          pwr_d   = 1'b0;
          arst_d  = 1'b0;
          link_d  = 1'b0;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  assign adc_pwr_en    = pwr_q;
  assign adc_rst_n     = arst_q;
  assign adc_cfg_start = start_q;
  assign link_rst_n    = link_q;
  assign sys_ready     = ready_q;
  assign cfg_err       = err_q;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Purpose : self-checking bench for rst_seq using a timeline model of the power-up sequence.
// Latency : outputs compared every cycle, 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_rst_seq;

  localparam int PW = 8;
  localparam int CT = 16;
  localparam int LW = 4;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       adc_cfg_done = 1'b0;
  logic       adc_pwr_en, adc_rst_n, adc_cfg_start, link_rst_n, sys_ready, cfg_err;
  logic [2:0] seq_state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Scenario description: PWR entered at edge m_e0, m_ntmo config attempts time out
  // (m_ntmo > MR means the run ends in FAULT), then config done is seen m_d cycles
  // after the final adc_cfg_start.
  int m_e0 = 1000000;
  int m_ntmo = 0;
  int m_d = 0;

  rst_seq #(
    .SYNC_STAGES (2),
    .PWR_WAIT    (16'd8),
    .CFG_TIMEOUT (16'd16),
    .LINK_WAIT   (16'd4),
    .MAX_RETRY   (2'd2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .soft_rst_req  (soft_rst_req),
    .adc_cfg_done  (adc_cfg_done),
    .adc_pwr_en    (adc_pwr_en),
    .adc_rst_n     (adc_rst_n),
    .adc_cfg_start (adc_cfg_start),
    .link_rst_n    (link_rst_n),
    .sys_ready     (sys_ready),
    .cfg_err       (cfg_err),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int attempt_start(input int a);
    return m_e0 + PW + a * (CT + PW);
  endfunction

  function automatic int seq_end();
    if (m_ntmo > MR) return attempt_start(MR) + CT;
    return attempt_start(m_ntmo) + m_d + 1 + LW;
  endfunction

  // done level to present for the edge after t
  function automatic logic done_next(input int t);
    return (m_ntmo <= MR) && (t >= attempt_start(m_ntmo) + m_d);
  endfunction

  // Expected {seq_state, pwr_en, adc_rst_n, cfg_start, link_rst_n, sys_ready, cfg_err} after edge t.
  function automatic logic [8:0] model_out(input int t);
    int s;
    logic [2:0] st;
    logic pw, ar, cs, lk, rd, er;
    st = 3'd0; pw = 0; ar = 0; cs = 0; lk = 0; rd = 0; er = 0;
    if (t >= m_e0) begin
      pw = 1; st = 3'd1;
      for (int a = 0; a <= m_ntmo && a <= MR; a++) begin
        s = attempt_start(a);
        if (t >= s) begin
          if (a < m_ntmo) begin
            if (t < s + CT) begin st = 3'd2; ar = 1; cs = (t == s); end
            else if (a == MR) begin st = 3'd5; ar = 0; er = 1; end
            else begin st = 3'd1; ar = 0; end
          end else begin
            ar = 1;
            if (t < s + m_d + 1) begin st = 3'd2; cs = (t == s); end
            else if (t < s + m_d + 1 + LW) begin st = 3'd3; lk = 1; end
            else begin st = 3'd4; lk = 1; rd = 1; end
          end
        end
      end
    end
    return {st, pw, ar, cs, lk, rd, er};
  endfunction

  function automatic logic [8:0] observed();
    return {seq_state, adc_pwr_en, adc_rst_n, adc_cfg_start, link_rst_n, sys_ready, cfg_err};
  endfunction

  // Advance one edge, sample outputs, then drive inputs for the following edge.
  task automatic tick(output logic [8:0] obs);
    @(posedge clk);
    #1;
    soft_rst_req = 1'b0;
    obs = observed();
    adc_cfg_done = done_next(cyc);
  endtask

  // Issue a soft restart sampled on the next edge, describing the new run.
  task automatic start_soft(input int ntmo, input int d);
    m_e0 = cyc + 1;
    m_ntmo = ntmo;
    m_d = d;
    adc_cfg_done = 1'b0;
    soft_rst_req = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(obs);
      n_checks++;
      if (obs !== 9'd0) $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, 9'd0);
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    logic [8:0] obs, exp;
    int n;
    rst_n = 1'b1;
    m_e0 = cyc + 3;
    m_ntmo = 0;
    m_d = 5;
    n = seq_end() + 2 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_soft_in_run_single_timeout();
    logic [8:0] obs, exp;
    int n;
    start_soft(1, int'($urandom_range(0, CT - 1)));
    n = seq_end() + 2 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL soft_run_retry cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_fault();
    logic [8:0] obs, exp;
    int n;
    start_soft(MR + 1, 0);
    n = seq_end() + 4 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL fault cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
    // leave FAULT through a soft restart into a fresh random run
    start_soft(int'($urandom_range(0, MR)), int'($urandom_range(0, CT - 1)));
    n = seq_end() + 2 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL fault_exit cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_tie();
    logic [8:0] obs, exp;
    int n;
    start_soft(int'($urandom_range(0, MR)), CT - 1);
    n = seq_end() + 2 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL tie cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] obs, exp;
    int n;
    start_soft(0, 10);
    n = attempt_start(0) + 4 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL async_pre cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
    // drop rst_n between edges; outputs must clear before the next edge
    #2 rst_n = 1'b0;
    #1;
    obs = observed();
    n_checks++;
    if (obs !== 9'd0) $display("FAIL async_drop cyc=%0d got=%b exp=%b", cyc, obs, 9'd0);
    else n_pass++;
    m_e0 = 1000000;
    for (int i = 0; i < 3; i++) begin
      tick(obs);
      n_checks++;
      if (obs !== 9'd0) $display("FAIL async_hold cyc=%0d got=%b exp=%b", cyc, obs, 9'd0);
      else n_pass++;
    end
    rst_n = 1'b1;
    m_e0 = cyc + 3;
    m_ntmo = 0;
    m_d = int'($urandom_range(0, CT - 1));
    n = seq_end() + 2 - cyc;
    for (int i = 0; i < n; i++) begin
      tick(obs);
      exp = model_out(cyc);
      n_checks++;
      if (obs !== exp) $display("FAIL async_restart cyc=%0d got=%b exp=%b", cyc, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_random_abort();
    logic [8:0] obs, exp;
    int n;
    for (int it = 0; it < 10; it++) begin
      start_soft(int'($urandom_range(0, MR + 1)), int'($urandom_range(0, CT - 1)));
      n = int'($urandom_range(1, seq_end() + 3 - m_e0));
      for (int i = 0; i < n; i++) begin
        tick(obs);
        exp = model_out(cyc);
        n_checks++;
        if (obs !== exp) $display("FAIL random_abort it=%0d cyc=%0d got=%b exp=%b", it, cyc, obs, exp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_soft_in_run_single_timeout();
    test_fault();
    test_tie();
    test_async_reset();
    test_random_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
